// File: rtl/phy_tx_pkg.sv
// Shared constants and state type for the PHY TX lane scheduler.
package phy_tx_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 2;
    localparam int unsigned BYTE_W    = 8;

    typedef enum logic [1:0] {IDLE, BURST, STALL} state_e;

endpackage

// File: rtl/phy_tx_lane_scheduler_rr_pick.sv
// Combinational round-robin finder: first valid lane at or after start_i, wrapping.
module phy_tx_rr_pick
    import phy_tx_pkg::*;
(
    input  logic [NUM_LANES-1:0] valid_i,
    input  logic [LANE_W-1:0]    start_i,
    output logic                 found_o,
    output logic [LANE_W-1:0]    lane_o
);

    logic [LANE_W-1:0] idx;

    // Scan from the farthest offset down so the nearest valid lane wins.
    always_comb begin
        found_o = 1'b0;
        lane_o  = start_i;
        idx     = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = start_i + LANE_W'(i);
            if (valid_i[idx]) begin
                found_o = 1'b1;
                lane_o  = idx;
            end
        end
    end

endmodule

// File: rtl/phy_tx_lane_scheduler.sv
// Round-robin burst scheduler sharing one registered byte path among four lanes.
// Optional per-lane byte and stall counters are built when PHY_TX_SCHED_STATS_EN is defined.
module phy_tx_lane_scheduler
    import phy_tx_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [BYTE_W-1:0] In0,
    input  logic [BYTE_W-1:0] In1,
    input  logic [BYTE_W-1:0] In2,
    input  logic [BYTE_W-1:0] In3,
    input  logic              valid0,
    input  logic              valid1,
    input  logic              valid2,
    input  logic              valid3,
    output logic              ready0,
    output logic              ready1,
    output logic              ready2,
    output logic              ready3,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic [LANE_W-1:0] lane_out,
    output logic              busy
`ifdef PHY_TX_SCHED_STATS_EN
    ,
    output logic [15:0]       byte_cnt0,
    output logic [15:0]       byte_cnt1,
    output logic [15:0]       byte_cnt2,
    output logic [15:0]       byte_cnt3,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   cur_lane_q, cur_lane_d;
    logic [LANE_W-1:0]   last_lane_q, last_lane_d;
    logic [3:0]          burst_cnt_q, burst_cnt_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [LANE_W-1:0]   lane_q, lane_d;

    logic [NUM_LANES-1:0] valid_vec;
    logic                 can_load, accept, found;
    logic [LANE_W-1:0]    acc_lane, pick_lane, scan_start;
    logic [BYTE_W-1:0]    acc_byte;

    assign valid_vec  = {valid3, valid2, valid1, valid0};
    assign can_load   = !valid_q || out_ready;
    // From IDLE continue after the last served lane; otherwise after the current one.
    assign scan_start = ((state_q == IDLE) ? last_lane_q : cur_lane_q) + LANE_W'(1);

    phy_tx_rr_pick u_pick (
        .valid_i (valid_vec),
        .start_i (scan_start),
        .found_o (found),
        .lane_o  (pick_lane)
    );

    always_comb begin
        state_d     = state_q;
        cur_lane_d  = cur_lane_q;
        last_lane_d = last_lane_q;
        burst_cnt_d = burst_cnt_q;
        accept      = 1'b0;
        acc_lane    = cur_lane_q;
        unique case (state_q)
            IDLE: begin
                if (enable && found && can_load) begin
                    accept      = 1'b1;
                    acc_lane    = pick_lane;
                    cur_lane_d  = pick_lane;
                    burst_cnt_d = 4'd1;
                    state_d     = BURST;
                end
            end
            BURST, STALL: begin
                if (!can_load) begin
                    state_d = STALL;
                end else if (valid_vec[cur_lane_q] && (burst_cnt_q < MaxBurst) && enable) begin
                    accept      = 1'b1;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    state_d     = BURST;
                end else begin
                    last_lane_d = cur_lane_q;
                    if (enable && found) begin
                        accept      = 1'b1;
                        acc_lane    = pick_lane;
                        cur_lane_d  = pick_lane;
                        burst_cnt_d = 4'd1;
                        state_d     = BURST;
                    end else begin
                        burst_cnt_d = 4'd0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_byte = In0;
        unique case (acc_lane)
            2'd0:    acc_byte = In0;
            2'd1:    acc_byte = In1;
            2'd2:    acc_byte = In2;
            default: acc_byte = In3;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        lane_d  = lane_q;
        valid_d = valid_q;
        if (can_load) begin
            if (accept) begin
                data_d  = acc_byte;
                lane_d  = acc_lane;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_lane_q  <= '0;
            last_lane_q <= LANE_W'(NUM_LANES - 1);
            burst_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            lane_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_lane_q  <= cur_lane_d;
            last_lane_q <= last_lane_d;
            burst_cnt_q <= burst_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            lane_q      <= lane_d;
        end
    end

    assign ready0    = accept && (acc_lane == 2'd0);
    assign ready1    = accept && (acc_lane == 2'd1);
    assign ready2    = accept && (acc_lane == 2'd2);
    assign ready3    = accept && (acc_lane == 2'd3);
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign lane_out  = lane_q;
    assign busy      = (state_q != IDLE);

`ifdef PHY_TX_SCHED_STATS_EN
    logic [15:0] byte_cnt_q [NUM_LANES];
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) byte_cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept) byte_cnt_q[acc_lane] <= byte_cnt_q[acc_lane] + 16'd1;
            if ((state_q == STALL) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign byte_cnt0 = byte_cnt_q[0];
    assign byte_cnt1 = byte_cnt_q[1];
    assign byte_cnt2 = byte_cnt_q[2];
    assign byte_cnt3 = byte_cnt_q[3];
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
